// File: rtl/nes_button_event_queue_if.sv
// APB3 slave bus bundle for the NES button event queue.
// The master modport drives the requests and the slave modport drives the responses.
interface nes_button_event_queue_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/nes_button_event_queue.sv
// Debounces NES controller button bytes, turns state changes into press/release
// events, and queues them in a FIFO that is drained over APB3 with an interrupt.
module nes_button_event_queue #(
    parameter int DEBOUNCE   = 3,
    parameter int DEPTH      = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                     PCLK,
    input  logic                     PRESERN,
    nes_button_event_queue_if.slave  apb,
    input  logic [7:0]               btn_state,
    input  logic                     btn_valid,
    output logic [7:0]               stable_state,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]    state;
    logic [7:0]    candidate;
    logic [3:0]    deb_cnt;
    logic [7:0]    pending;
    logic          overflow;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;

    logic [7:0]    s_norm;
    logic [7:0]    cand_nxt;
    logic [3:0]    cnt_nxt;
    logic          accept;
    logic [2:0]    emit_idx;
    logic [7:0]    pend_clr;
    logic [7:0]    emit_evt;
    logic          emitting;
    logic          pop;
    logic          push;
    logic          drop;
    logic          wr_ctrl;
    logic          flush;
    logic          ovf_clr;
    logic [4:0]    cnt5;
    logic          unused_pwdata;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign cnt5  = 5'(count);
    assign unused_pwdata = ^apb.PWDATA[31:2];

    // Debounce next-state; acceptance looks at the post-update candidate and count.
    always_comb begin
        s_norm   = (ACTIVE_LOW != 0) ? ~btn_state : btn_state;
        cand_nxt = candidate;
        cnt_nxt  = deb_cnt;
        if (btn_valid) begin
            if (s_norm == candidate) begin
                if (deb_cnt != 4'(DEBOUNCE))
                    cnt_nxt = deb_cnt + 4'd1;
            end else begin
                cand_nxt = s_norm;
                cnt_nxt  = 4'd1;
            end
        end
        accept = btn_valid && (cnt_nxt == 4'(DEBOUNCE)) &&
                 (cand_nxt != stable_state) && (pending == '0);
    end

    always_comb begin
        emit_idx = 3'd0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (pending[i-1])
                emit_idx = 3'(i - 1);
        end
        pend_clr = pending & ~(8'h01 << emit_idx);
        emit_evt = {stable_state[emit_idx], 4'b0000, emit_idx};
        emitting = (state == EMIT);
    end

    // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
    always_comb begin
        pop     = apb.PSEL && apb.PENABLE && !apb.PWRITE && (apb.PADDR == 8'h00) && !empty;
        wr_ctrl = apb.PSEL && apb.PENABLE && apb.PWRITE && (apb.PADDR == 8'h08);
        flush   = wr_ctrl && apb.PWDATA[1];
        ovf_clr = wr_ctrl && apb.PWDATA[0];
        push    = emitting && (!full || pop) && !flush;
        drop    = emitting && full && !pop;
    end

    always_ff @(posedge PCLK or posedge PRESERN) begin
        if (PRESERN) begin
            state        <= IDLE;
            candidate    <= '0;
            deb_cnt      <= '0;
            stable_state <= '0;
            pending      <= '0;
        end else begin
            candidate <= cand_nxt;
            deb_cnt   <= cnt_nxt;
            if (accept) begin
                stable_state <= cand_nxt;
                pending      <= cand_nxt ^ stable_state;
            end else if (emitting) begin
                pending <= pend_clr;
            end
            case (state)
                IDLE:    if (accept || (pending != '0)) state <= EMIT;
                EMIT:    if (pend_clr == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESERN) begin
        if (PRESERN) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + AW'(1);
                if (pop)  rptr <= rptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            irq <= !empty;
        end
    end

    always_ff @(posedge PCLK) begin
        if (push)
            mem[wptr] <= emit_evt;
    end

    always_comb begin
        case (apb.PADDR)
            8'h00:   apb.PRDATA = empty ? '0 : {24'd0, mem[rptr]};
            8'h04:   apb.PRDATA = {8'd0, stable_state, 3'd0, cnt5, 5'd0, overflow, full, empty};
            default: apb.PRDATA = '0;
        endcase
    end

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;

endmodule

// File: tb/tb_nes_button_event_queue.sv
// Directed bench for nes_button_event_queue: debounce, event ordering, overflow,
// flush, full-FIFO push/pop collision and reset during drain.
module tb_nes_button_event_queue;

    logic       PCLK;
    logic       PRESERN;
    logic [7:0] btn_state;
    logic       btn_valid;
    logic [7:0] stable_state;
    logic       irq;

    int checks;
    int failures;

    nes_button_event_queue_if apb_bus ();

    nes_button_event_queue #(
        .DEBOUNCE   (3),
        .DEPTH      (8),
        .ACTIVE_LOW (1)
    ) dut (
        .PCLK         (PCLK),
        .PRESERN      (PRESERN),
        .apb          (apb_bus),
        .btn_state    (btn_state),
        .btn_valid    (btn_valid),
        .stable_state (stable_state),
        .irq          (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input logic [7:0] b);
        btn_state = b;
        btn_valid = 1'b1;
        tick();
        btn_valid = 1'b0;
    endtask

    task automatic strobe3(input logic [7:0] b);
        repeat (3) strobe(b);
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
        apb_bus.PSEL    = 1'b1;
        apb_bus.PENABLE = 1'b0;
        apb_bus.PWRITE  = 1'b0;
        apb_bus.PADDR   = addr;
        tick();
        apb_bus.PENABLE = 1'b1;
        #1;
        data = apb_bus.PRDATA;
        tick();
        apb_bus.PSEL    = 1'b0;
        apb_bus.PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        apb_bus.PSEL    = 1'b1;
        apb_bus.PENABLE = 1'b0;
        apb_bus.PWRITE  = 1'b1;
        apb_bus.PADDR   = addr;
        apb_bus.PWDATA  = data;
        tick();
        apb_bus.PENABLE = 1'b1;
        tick();
        apb_bus.PSEL    = 1'b0;
        apb_bus.PENABLE = 1'b0;
        apb_bus.PWRITE  = 1'b0;
    endtask

    logic [31:0] rd;
    logic [7:0]  b;
    logic [7:0]  exp_ev [8];

    initial begin
        checks   = 0;
        failures = 0;
        PRESERN  = 1'b0;
        btn_state = 8'hFF;
        btn_valid = 1'b0;
        apb_bus.PSEL    = 1'b0;
        apb_bus.PENABLE = 1'b0;
        apb_bus.PWRITE  = 1'b0;
        apb_bus.PADDR   = 8'h00;
        apb_bus.PWDATA  = '0;
        #1 PRESERN = 1'b1;
        idle(3);
        PRESERN = 1'b0;
        idle(1);

        check("reset_stable", {24'd0, stable_state}, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        apb_read(8'h04, rd);
        check("reset_status", rd, 32'h0000_0001);
        apb_read(8'h0C, rd);
        check("unmapped_read", rd, 32'h0);

        // Single press of button 0, including push and irq latency
        strobe3(8'hFE);
        check("press0_stable", {24'd0, stable_state}, 32'h01);
        idle(1);
        check("irq_latency_low", {31'd0, irq}, 32'h0);
        idle(1);
        check("irq_high", {31'd0, irq}, 32'h1);
        apb_read(8'h04, rd);
        check("press0_status", rd, 32'h0001_0100);
        apb_read(8'h00, rd);
        check("press0_event", rd, 32'h80);
        strobe3(8'hFF);
        idle(2);
        apb_read(8'h00, rd);
        check("release0_event", rd, 32'h00);

        // Bouncing input only accepted after three identical samples
        strobe(8'hFE);
        strobe(8'hFF);
        strobe(8'hFE);
        strobe(8'hFE);
        idle(3);
        apb_read(8'h04, rd);
        check("bounce_no_event", rd, 32'h0000_0001);
        strobe(8'hFE);
        idle(3);
        apb_read(8'h04, rd);
        check("bounce_accept_status", rd, 32'h0001_0100);
        apb_read(8'h00, rd);
        check("bounce_event", rd, 32'h80);
        strobe3(8'hFF);
        idle(3);
        apb_read(8'h00, rd);
        check("bounce_release", rd, 32'h00);

        // Simultaneous press/release of buttons 0, 3, 7
        strobe3(8'h76);
        check("multi_stable", {24'd0, stable_state}, 32'h89);
        idle(5);
        strobe3(8'hFF);
        idle(5);
        apb_read(8'h04, rd);
        check("multi_count", rd, 32'h0000_0600);
        apb_read(8'h00, rd); check("multi_ev0", rd, 32'h80);
        apb_read(8'h00, rd); check("multi_ev1", rd, 32'h83);
        apb_read(8'h00, rd); check("multi_ev2", rd, 32'h87);
        apb_read(8'h00, rd); check("multi_ev3", rd, 32'h00);
        apb_read(8'h00, rd); check("multi_ev4", rd, 32'h03);
        apb_read(8'h00, rd); check("multi_ev5", rd, 32'h07);
        apb_read(8'h00, rd); check("empty_read", rd, 32'h0);
        idle(2);
        check("irq_cleared", {31'd0, irq}, 32'h0);

        // Ten events into an eight-deep FIFO
        for (int k = 0; k < 5; k++) begin
            b = ~(8'h01 << k);
            strobe3(b);
            idle(2);
            strobe3(8'hFF);
            idle(2);
        end
        for (int k = 0; k < 4; k++) begin
            exp_ev[2*k]   = 8'h80 | 8'(k);
            exp_ev[2*k+1] = 8'(k);
        end
        apb_read(8'h04, rd);
        check("ovf_status", rd, 32'h0000_0806);
        apb_write(8'h08, 32'h1);
        apb_read(8'h04, rd);
        check("ovf_cleared", rd, 32'h0000_0802);
        for (int k = 0; k < 8; k++) begin
            apb_read(8'h00, rd);
            check($sformatf("ovf_ev%0d", k), rd, {24'd0, exp_ev[k]});
        end
        apb_read(8'h04, rd);
        check("ovf_drained", rd, 32'h0000_0001);
        strobe3(8'hDF);
        idle(3);
        apb_write(8'h08, 32'h2);
        apb_read(8'h04, rd);
        check("flush_status", rd, 32'h0020_0001);
        strobe3(8'hFF);
        idle(3);
        apb_read(8'h00, rd);
        check("post_flush_event", rd, 32'h05);

        // Full FIFO: APB pop on the same edge as the EMIT push
        for (int k = 0; k < 4; k++) begin
            b = ~(8'h01 << k);
            strobe3(b);
            idle(2);
            strobe3(8'hFF);
            idle(2);
        end
        apb_read(8'h04, rd);
        check("full_before", rd, 32'h0000_0802);
        strobe(8'hBF);
        strobe(8'hBF);
        btn_state = 8'hBF;
        btn_valid = 1'b1;
        apb_bus.PSEL    = 1'b1;
        apb_bus.PENABLE = 1'b0;
        apb_bus.PWRITE  = 1'b0;
        apb_bus.PADDR   = 8'h00;
        tick();
        btn_valid = 1'b0;
        apb_bus.PENABLE = 1'b1;
        #1;
        rd = apb_bus.PRDATA;
        tick();
        apb_bus.PSEL    = 1'b0;
        apb_bus.PENABLE = 1'b0;
        check("collide_head", rd, 32'h80);
        apb_read(8'h04, rd);
        check("collide_status", rd, 32'h0040_0802);
        apb_read(8'h00, rd);
        check("collide_next", rd, 32'h00);
        strobe3(8'hFF);
        idle(3);
        apb_write(8'h08, 32'h2);
        apb_read(8'h04, rd);
        check("collide_flushed", rd, 32'h0000_0001);

        // Reset while draining three pending bits
        strobe3(8'h76);
        PRESERN = 1'b1;
        #1;
        check("rst_mid_stable", {24'd0, stable_state}, 32'h0);
        check("rst_mid_irq", {31'd0, irq}, 32'h0);
        idle(2);
        PRESERN = 1'b0;
        idle(5);
        apb_read(8'h04, rd);
        check("rst_mid_status", rd, 32'h0000_0001);
        apb_read(8'h00, rd);
        check("rst_mid_event", rd, 32'h0);
        check("rst_mid_irq_after", {31'd0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nes_button_event_queue.md
Name: nes_button_event_queue

Overview:
- Sits directly downstream of the NES controller serial reader; consumes each completed 8-bit button byte plus a one-cycle valid strobe.
- Debounces the byte and turns stable per-button transitions into press/release events.
- Queues events in a small FIFO that firmware drains over APB3, and raises an interrupt while events are pending.

Parameters:
- DEBOUNCE, 3, consecutive identical samples needed before a new button state is accepted (1..15).
- DEPTH, 8, FIFO entries (power of two, 2..16).
- ACTIVE_LOW, 1, 1 = raw button bits are 0 when pressed; they are inverted on input.

Ports:
- PCLK  in  1  system clock; all state changes on rising edge.
- PRESERN  in  1  reset, asynchronous, active-high.
- PSEL  in  1  APB peripheral select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  APB direction; 1 = write.
- PADDR  in  8  APB byte address.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  tied to 1; zero wait states.
- PSLVERR  out  1  tied to 0.
- btn_state  in  8  raw button byte from the controller reader; bit i is button i.
- btn_valid  in  1  one-cycle strobe; btn_state is valid this cycle.
- stable_state  out  8  debounced state, 1 = pressed.
- irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset, asynchronous: stable_state=0, candidate=0, deb_cnt=0, pending=0, FIFO empty with pointers 0, overflow=0, irq=0. Reset mid-drain or mid-debounce discards all state.
- Normalise: s = ACTIVE_LOW ? ~btn_state : btn_state. Only cycles with btn_valid=1 are sampled.
- Debounce on btn_valid:
  - If s==candidate, deb_cnt increments, saturating at DEBOUNCE.
  - Otherwise candidate<=s and deb_cnt<=1.
  - Accept is evaluated on the post-update count: when count==DEBOUNCE, candidate!=stable_state, and pending==0, then stable_state<=candidate and pending<=candidate^stable_state.
  - If pending!=0, acceptance is deferred to a later sample; the saturated count keeps it eligible.
- Drain FSM, states IDLE and EMIT:
  - IDLE->EMIT when pending!=0.
  - In EMIT, each cycle takes idx = lowest set bit of pending and forms event = {press=stable_state[idx], 4'b0, idx[2:0]}, then clears pending[idx].
  - If the FIFO is not full, the event is pushed. If the FIFO is full, the event is dropped and overflow<=1.
  - EMIT->IDLE when the cleared mask is zero. With 8 buttons, at most 8 cycles per accepted change.
- FIFO:
  - A pop happens on an APB read of 0x00 with PSEL&PENABLE&~PWRITE and the FIFO non-empty.
  - Push and pop in the same cycle: both occur and count is unchanged. When full, a same-cycle pop makes room, so no overflow.
  - Pop when empty: no state change.
  - Pointers wrap modulo DEPTH; count has width log2(DEPTH)+1.
- APB registers. PRDATA is a combinational mux of PADDR and current registers; unmapped addresses read 0.
  - 0x00 EVENT (read): {24'd0, head event}; reads 0 when empty; the access phase pops.
  - 0x04 STATUS (read): [0] empty, [1] full, [2] overflow, [12:8] count, [23:16] stable_state, others 0.
  - 0x08 CTRL (write, access phase): bit0=1 clears overflow; bit1=1 flushes the FIFO (pointers and count to 0).
  - Flush in the same cycle as a push: flush wins and the push is lost. Overflow set and clear in the same cycle: set wins.
  - Writes to other addresses are ignored.
- irq: registered, equal to the previous cycle's ~empty. One-cycle latency after push or pop.
- Latency: from the btn_valid that completes debounce, the first event is in the FIFO 2 cycles later (accept cycle, then EMIT push).

Test Plan:
- Reset, then ACTIVE_LOW=1, btn_state=8'hFE strobed 3 times -> stable_state=8'h01; after the 3rd strobe, FIFO holds 8'h80; irq=1; STATUS count=1.
- Bouncing sequence FE, FF, FE, FE -> no event after the 2nd FE; event 8'h80 after the 3rd FE.
- Press buttons 0, 3, 7 simultaneously (8'h76 x3), then release (8'hFF x3) -> read order 80, 83, 87, 00, 03, 07; then empty reads 0 and irq=0.
- Generate 10 events with no reads (DEPTH=8) -> full=1, overflow=1, first 8 events retained in order. Write CTRL=1 -> overflow=0. Write CTRL=2 -> empty=1.
- FIFO full while an APB pop coincides with an EMIT push -> count stays 8, overflow stays 0, next read returns the 2nd-oldest event.
- Assert PRESERN during EMIT with 3 pending bits -> FIFO empty, irq=0, stable_state=0 immediately. After release, no stale events appear.
